// File: rtl/fejkon_csr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fejkon_csr_arbiter
//  Purpose  : Round-robin arbiter sharing one fixed-latency Avalon-MM CSR
//             slave between two masters (A = PCIe BAR path, B = JTAG/debug).
//             One transaction is in flight at a time. All outputs registered.
//  Ports    : clk, reset_n            clock, async active-low reset
//             a_* / b_*               Avalon-MM slave ports facing masters
//                                     (address, read, write, writedata in;
//                                      waitrequest, readdata, readdatavalid out)
//             s_*                     Avalon-MM master port to the CSR slave
//                                     (address, read, write, writedata out;
//                                      readdata in)
//  Revision : 1.0  initial release
// ============================================================================
module fejkon_csr_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // WAIT counts down to zero; the capture happens on the zero cycle, so the
  // load value is one less than the slave latency.
  localparam logic [1:0] c_cnt_load = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  state_t              r_state;
  logic                r_last_b;   // 1: B was granted last, so A has priority
  logic                r_grant_b;  // owner of the transaction in flight
  logic                r_is_write;
  logic [1:0]          r_cnt;

  logic                r_a_waitrequest;
  logic                r_b_waitrequest;
  logic [DATA_W-1:0]   r_a_readdata;
  logic [DATA_W-1:0]   r_b_readdata;
  logic                r_a_readdatavalid;
  logic                r_b_readdatavalid;
  logic [ADDR_W-1:0]   r_s_address;
  logic                r_s_read;
  logic                r_s_write;
  logic [DATA_W-1:0]   r_s_writedata;

  logic                w_a_req;
  logic                w_b_req;
  logic                w_pick_b;
  logic                w_cmd_write;
  logic                w_capture;

  assign w_a_req     = a_read | a_write;
  assign w_b_req     = b_read | b_write;
  // B wins when it is the only requester, or on contention when A went last.
  assign w_pick_b    = w_b_req & (~w_a_req | ~r_last_b);
  // Write takes precedence if a master raises read and write together.
  assign w_cmd_write = w_pick_b ? b_write : a_write;

  // Slave read data is sampled in ISSUE for a combinational slave, otherwise
  // on the last WAIT cycle.
  assign w_capture = ((r_state == ST_ISSUE) && !r_is_write && (READ_LATENCY == 0)) ||
                     ((r_state == ST_WAIT) && (r_cnt == 2'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= ST_IDLE;
      r_last_b          <= 1'b1;
      r_grant_b         <= 1'b0;
      r_is_write        <= 1'b0;
      r_cnt             <= 2'd0;
      r_a_waitrequest   <= 1'b1;
      r_b_waitrequest   <= 1'b1;
      r_a_readdata      <= '0;
      r_b_readdata      <= '0;
      r_a_readdatavalid <= 1'b0;
      r_b_readdatavalid <= 1'b0;
      r_s_address       <= '0;
      r_s_read          <= 1'b0;
      r_s_write         <= 1'b0;
      r_s_writedata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_a_req || w_b_req) begin
            r_grant_b       <= w_pick_b;
            r_last_b        <= w_pick_b;
            r_is_write      <= w_cmd_write;
            r_s_address     <= w_pick_b ? b_address : a_address;
            r_s_writedata   <= w_pick_b ? b_writedata : a_writedata;
            r_s_write       <= w_cmd_write;
            r_s_read        <= ~w_cmd_write;
            // Drop waitrequest so it is low exactly during ISSUE.
            r_a_waitrequest <= w_pick_b;
            r_b_waitrequest <= ~w_pick_b;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_a_waitrequest <= 1'b1;
          r_b_waitrequest <= 1'b1;
          r_s_read        <= 1'b0;
          r_s_write       <= 1'b0;
          if (r_is_write) begin
            r_state <= ST_IDLE;
          end else if (READ_LATENCY == 0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= c_cnt_load;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          r_a_readdatavalid <= 1'b0;
          r_b_readdatavalid <= 1'b0;
          r_state           <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // readdata is only updated on capture and holds otherwise.
      if (w_capture) begin
        if (r_grant_b) begin
          r_b_readdata      <= s_readdata;
          r_b_readdatavalid <= 1'b1;
        end else begin
          r_a_readdata      <= s_readdata;
          r_a_readdatavalid <= 1'b1;
        end
      end
    end
  end

  assign a_waitrequest   = r_a_waitrequest;
  assign b_waitrequest   = r_b_waitrequest;
  assign a_readdata      = r_a_readdata;
  assign b_readdata      = r_b_readdata;
  assign a_readdatavalid = r_a_readdatavalid;
  assign b_readdatavalid = r_b_readdatavalid;
  assign s_address       = r_s_address;
  assign s_read          = r_s_read;
  assign s_write         = r_s_write;
  assign s_writedata     = r_s_writedata;

endmodule
`default_nettype wire
